// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit FND scan sequencer with guard blanking, LZB and frame-synchronous update
//
// Purpose:
//   Steps the digit select 0..3. Each digit slot is GUARD_CYCLES blanked clocks
//   followed by DIV_COUNT lit clocks. The block presents the selected BCD nibble
//   and decimal point to the segment decoder, and drives the blank input of the
//   select decoder. The displayed value (shadow) is replaced only at the 3->0 wrap,
//   so a frame never shows a mix of old and new digits.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous reset, active-high
//   i_en           1 = scanning, 0 = display off
//   i_value[15:0]  four BCD digits, [3:0] = digit0 (LSD)
//   i_load         1-clk strobe, captures i_value
//   i_dpMask[3:0]  decimal point per digit
//   i_lzb          leading-zero blanking enable
//   o_digitSelect  current digit index
//   o_blank        1 = all digit strobes off
//   o_bcd          BCD nibble of the current digit
//   o_dp           decimal point of the current digit
//   o_frame        1-clk pulse after each 3->0 wrap
module fnd_scan_controller #(
  parameter int DIV_COUNT    = 100_000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic        i_load,
  input  logic [3:0]  i_dpMask,
  input  logic        i_lzb,
  output logic [1:0]  o_digitSelect,
  output logic        o_blank,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_frame
);

  localparam int CNT_MAX = (DIV_COUNT > GUARD_CYCLES) ? DIV_COUNT : GUARD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_COUNT - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_GUARD = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sel_n;
  logic [15:0]   shadow, shadow_n;
  logic [15:0]   pending, pending_n;
  logic          pend_valid, pend_valid_n;
  logic          wrap;
  logic          lz;
  logic          blank_n;
  logic [3:0]    bcd_n;
  logic          dp_n;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = o_digitSelect;
    shadow_n     = shadow;
    pending_n    = pending;
    pend_valid_n = pend_valid;
    wrap         = 1'b0;
    lz           = 1'b0;
    bcd_n        = 4'h0;

    // Sequencing: disabling wins over every other transition.
    if (!i_en) begin
      state_n = S_OFF;
      cnt_n   = '0;
      sel_n   = 2'd0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = S_GUARD;
          cnt_n   = '0;
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state_n = S_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_SHOW: begin
          if (cnt == DIV_LAST) begin
            state_n = S_GUARD;
            cnt_n   = '0;
            sel_n   = o_digitSelect + 2'd1;
            wrap    = (o_digitSelect == 2'd3);
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
          sel_n   = 2'd0;
        end
      endcase
    end

    // Value path: while off there is no frame to tear, so loads land directly.
    // A load on the wrap edge is newer than anything pending and takes precedence.
    if (state == S_OFF) begin
      if (i_load) begin
        shadow_n     = i_value;
        pend_valid_n = 1'b0;
      end
    end else if (wrap) begin
      if (i_load) begin
        shadow_n = i_value;
      end else if (pend_valid) begin
        shadow_n = pending;
      end
      pend_valid_n = 1'b0;
    end else if (i_load) begin
      pending_n    = i_value;
      pend_valid_n = 1'b1;
    end

    // Outputs are computed from next-state values so the registers line up
    // with the state they describe.
    case (sel_n)
      2'd0: bcd_n = shadow_n[3:0];
      2'd1: bcd_n = shadow_n[7:4];
      2'd2: bcd_n = shadow_n[11:8];
      default: bcd_n = shadow_n[15:12];
    endcase

    case (sel_n)
      2'd1: lz = (shadow_n[15:4] == 12'h000);
      2'd2: lz = (shadow_n[15:8] == 8'h00);
      2'd3: lz = (shadow_n[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase

    blank_n = (state_n != S_SHOW) || (i_lzb && lz);
    dp_n    = !blank_n && i_dpMask[sel_n];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_OFF;
      cnt           <= '0;
      shadow        <= 16'h0000;
      pending       <= 16'h0000;
      pend_valid    <= 1'b0;
      o_digitSelect <= 2'd0;
      o_blank       <= 1'b1;
      o_bcd         <= 4'h0;
      o_dp          <= 1'b0;
      o_frame       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      shadow        <= shadow_n;
      pending       <= pending_n;
      pend_valid    <= pend_valid_n;
      o_digitSelect <= sel_n;
      o_blank       <= blank_n;
      o_bcd         <= bcd_n;
      o_dp          <= dp_n;
      o_frame       <= wrap;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - self-checking bench for fnd_scan_controller
module tb_fnd_scan_controller;

  localparam int DIV = 4;
  localparam int GRD = 1;
  localparam int PER = DIV + GRD;
  localparam int FRM = 4 * PER;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = 4'h0;
  logic        lzb = 1'b0;
  logic [1:0]  sel;
  logic        blank;
  logic [3:0]  bcd;
  logic        dp;
  logic        frame;

  fnd_scan_controller #(.DIV_COUNT(DIV), .GUARD_CYCLES(GRD)) dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_value(value), .i_load(load),
    .i_dpMask(dp_mask), .i_lzb(lzb), .o_digitSelect(sel), .o_blank(blank),
    .o_bcd(bcd), .o_dp(dp), .o_frame(frame)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: position t within a frame since scanning started.
  // Slot = t / PER, lit when t % PER >= GRD, wrap when t returns to 0.
  bit          started = 0;
  bit          m_on;
  int          t;
  logic [15:0] m_shadow, m_pending;
  bit          m_pv;
  bit          m_wrap;
  bit          m_lit;
  bit          m_sup;
  logic [1:0]  e_sel;
  logic        e_blank, e_dp, e_frame;
  logic [3:0]  e_bcd;

  initial forever begin
    @(posedge clk);
    m_wrap = 0;
    if (reset) begin
      m_on = 0; t = 0; m_shadow = 16'h0; m_pending = 16'h0; m_pv = 0;
    end else if (!en) begin
      if (!m_on) begin
        if (load) begin m_shadow = value; m_pv = 0; end
      end else if (load) begin
        m_pending = value; m_pv = 1;
      end
      m_on = 0;
    end else if (!m_on) begin
      if (load) begin m_shadow = value; m_pv = 0; end
      m_on = 1;
      t = 0;
    end else begin
      t = (t + 1) % FRM;
      m_wrap = (t == 0);
      if (m_wrap) begin
        if (load) m_shadow = value;
        else if (m_pv) m_shadow = m_pending;
        m_pv = 0;
      end else if (load) begin
        m_pending = value; m_pv = 1;
      end
    end
    if (m_on) begin
      e_sel   = 2'((t / PER) % 4);
      m_lit   = (t % PER) >= GRD;
      m_sup   = lzb && (e_sel != 2'd0) && ((m_shadow >> (4 * e_sel)) == 16'h0);
      e_blank = !m_lit || m_sup;
      e_dp    = !e_blank && dp_mask[e_sel];
      e_frame = m_wrap;
    end else begin
      e_sel = 2'd0; e_blank = 1'b1; e_dp = 1'b0; e_frame = 1'b0;
    end
    e_bcd = m_shadow[4 * e_sel +: 4];
    started = 1;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("m_sel",   16'(sel),   16'(e_sel));
      chk("m_blank", 16'(blank), 16'(e_blank));
      chk("m_bcd",   16'(bcd),   16'(e_bcd));
      chk("m_dp",    16'(dp),    16'(e_dp));
      chk("m_frame", 16'(frame), 16'(e_frame));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int max);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!frame && n < max);
    chk("frame_timeout", 16'(frame), 16'd1);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
    return v;
  endfunction

  logic [3:0] d1234 [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
  logic [3:0] d0050 [4] = '{4'd0, 4'd5, 4'd0, 4'd0};
  bit   t1_blank [7] = '{1, 0, 0, 0, 0, 1, 0};
  int   t1_sel   [7] = '{0, 0, 0, 0, 0, 1, 1};
  int   lit_cnt  [4];
  int   dp_cnt;

  initial begin
    // 1: reset held with enable high, then first slots
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_blank", 16'(blank), 16'd1);
      chk("rst_sel",   16'(sel),   16'd0);
      chk("rst_frame", 16'(frame), 16'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t1_blank", 16'(blank), 16'(t1_blank[i]));
      chk("t1_sel",   16'(sel),   16'(t1_sel[i]));
    end

    // 2: value 1234 appears from next frame, frame pulse every FRM clocks
    value = 16'h1234; load = 1'b1;
    cyc();
    load = 1'b0;
    wait_frame(2 * FRM);
    chk("t2_wrap_bcd", 16'(bcd), 16'd4);
    for (int i = 1; i <= FRM; i++) begin
      cyc();
      if (!blank) chk("t2_bcd", 16'(bcd), 16'(d1234[sel]));
      chk("t2_frame", 16'(frame), 16'(i == FRM));
    end

    // 3: leading-zero blanking
    lzb = 1'b1; value = 16'h0050; load = 1'b1;
    cyc();
    load = 1'b0;
    wait_frame(2 * FRM);
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
    for (int i = 1; i <= FRM; i++) begin
      cyc();
      if (!blank) begin
        lit_cnt[sel]++;
        chk("t3_bcd", 16'(bcd), 16'(d0050[sel]));
      end
    end
    chk("t3_lit0", 16'(lit_cnt[0]), 16'd4);
    chk("t3_lit1", 16'(lit_cnt[1]), 16'd4);
    chk("t3_lit2", 16'(lit_cnt[2]), 16'd0);
    chk("t3_lit3", 16'(lit_cnt[3]), 16'd0);
    value = 16'h0000; load = 1'b1;
    cyc();
    load = 1'b0;
    wait_frame(2 * FRM);
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
    for (int i = 1; i <= FRM; i++) begin
      cyc();
      if (!blank) begin
        lit_cnt[sel]++;
        chk("t3z_bcd", 16'(bcd), 16'd0);
      end
    end
    chk("t3z_lit0", 16'(lit_cnt[0]), 16'd4);
    chk("t3z_lit1", 16'(lit_cnt[1] + lit_cnt[2] + lit_cnt[3]), 16'd0);

    // 4: mid-frame load waits for wrap; load on the wrap edge shows at once
    lzb = 1'b0;
    repeat (6) cyc();
    chk("t4_sel1", 16'(sel), 16'd1);
    value = 16'h9999; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      if (i < 13) begin
        if (!blank) chk("t4_old", 16'(bcd), 16'd0);
      end else begin
        chk("t4_wrap", 16'(frame), 16'd1);
        chk("t4_new", 16'(bcd), 16'd9);
      end
    end
    for (int i = 1; i < FRM; i++) begin
      cyc();
      if (!blank) chk("t4_nines", 16'(bcd), 16'd9);
    end
    value = 16'h4321; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("t4c_frame", 16'(frame), 16'd1);
    chk("t4c_bcd", 16'(bcd), 16'd1);
    cyc();
    chk("t4c_lit", 16'(blank), 16'd0);
    chk("t4c_bcd0", 16'(bcd), 16'd1);

    // 5: disable during digit 2, re-enable, reset mid-slot
    repeat (10) cyc();
    chk("t5_sel2", 16'(sel), 16'd2);
    chk("t5_lit", 16'(blank), 16'd0);
    en = 1'b0;
    cyc();
    chk("t5_off_blank", 16'(blank), 16'd1);
    chk("t5_off_sel", 16'(sel), 16'd0);
    chk("t5_off_dp", 16'(dp), 16'd0);
    en = 1'b1;
    cyc();
    chk("t5_guard", 16'(blank), 16'd1);
    cyc();
    chk("t5_d0_lit", 16'(blank), 16'd0);
    chk("t5_d0_sel", 16'(sel), 16'd0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_rst_blank", 16'(blank), 16'd1);
    chk("t5_rst_sel", 16'(sel), 16'd0);
    chk("t5_rst_bcd", 16'(bcd), 16'd0);
    chk("t5_rst_dp", 16'(dp), 16'd0);
    chk("t5_rst_frame", 16'(frame), 16'd0);

    // 6: decimal point only on lit digit 2
    dp_mask = 4'b0100;
    dp_cnt = 0;
    for (int i = 0; i < FRM; i++) begin
      cyc();
      if (dp) dp_cnt++;
      chk("t6_dp", 16'(dp), 16'(sel == 2'd2 && !blank));
    end
    chk("t6_dp_cnt", 16'(dp_cnt), 16'd4);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(999) < 3);
      en    = ($urandom_range(99) < 97);
      load  = ($urandom_range(99) < 8);
      value = rand_val();
      if ($urandom_range(99) < 5) lzb = 1'($urandom_range(1));
      if ($urandom_range(99) < 5) dp_mask = 4'($urandom_range(15));
      cyc();
    end
    reset = 1'b0; load = 1'b0; en = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
